// File: rtl/ifu_pkg.sv
// Shared core package for the fetch unit.
// Address map defaults, exception codes and fetch state encoding.
package ifu_pkg;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam logic [31:0] IM_BASE  = 32'h0000_3000;
  localparam logic [31:0] IM_LIMIT = 32'h0000_6ffc;

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_FULL  = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/ifu.sv
// Instruction-fetch stage: owns the PC, fetches over req/gnt/rvalid,
// buffers one instruction for F/D, applies delayed redirects and flushes.
// Ports: clk, reset (async active-low); enable/flush/redirect control;
// imem_* fetch handshake; F_pc/F_instr/F_valid/F_exc toward F/D.
module ifu
  import ifu_pkg::*;
#(
  parameter logic [31:0] P_RESET_PC = RESET_PC,
  parameter logic [31:0] P_IM_BASE  = IM_BASE,
  parameter logic [31:0] P_IM_LIMIT = IM_LIMIT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] F_pc,
  output logic [31:0] F_instr,
  output logic        F_valid,
  output logic [4:0]  F_exc
);

  fetch_state_t state;
  logic [31:0]  pc;
  logic [31:0]  ibuf;
  logic [4:0]   exc;
  logic         valid;
  logic         drop;
  logic         redir_pend;
  logic [31:0]  redir_tgt;

  logic         legal;
  logic         granted;
  logic         consume;
  logic [31:0]  next_pc;

  assign legal = (pc[1:0] == 2'b00)
              && (pc >= P_IM_BASE)
              && (pc <= P_IM_LIMIT);

  assign imem_req = reset
                 && (state == ST_FETCH)
                 && legal;

  assign granted = imem_req && imem_gnt;
  assign consume = (state == ST_FULL) && enable;

  // A redirect arriving with the consume wins over a stale pending one.
  assign next_pc = redirect   ? redirect_pc :
                   redir_pend ? redir_tgt   :
                                pc + 32'd4;

  assign imem_addr = pc;
  assign F_pc      = pc;
  assign F_instr   = ibuf;
  assign F_valid   = valid;
  assign F_exc     = exc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_FETCH;
      pc         <= P_RESET_PC;
      ibuf       <= 32'd0;
      exc        <= EXC_NONE;
      valid      <= 1'b0;
      drop       <= 1'b0;
      redir_pend <= 1'b0;
      redir_tgt  <= 32'd0;
    end else if (flush) begin
      pc         <= flush_pc;
      redir_pend <= 1'b0;
      ibuf       <= 32'd0;
      exc        <= EXC_NONE;
      valid      <= 1'b0;
      unique case (state)
        ST_FETCH: begin
          // A request granted now still returns data; mark it stale.
          state <= granted ? ST_WAIT : ST_FETCH;
          drop  <= granted;
        end
        ST_WAIT: begin
          if (imem_rvalid) begin
            state <= ST_FETCH;
            drop  <= 1'b0;
          end else begin
            drop  <= 1'b1;
          end
        end
        default: begin
          state <= ST_FETCH;
          drop  <= 1'b0;
        end
      endcase
    end else begin
      // The instruction in F when a redirect lands is the delay slot,
      // so the target is held until that slot is consumed.
      if (consume) begin
        redir_pend <= 1'b0;
      end else if (redirect) begin
        redir_pend <= 1'b1;
        redir_tgt  <= redirect_pc;
      end
      unique case (state)
        ST_FETCH: begin
          if (!legal) begin
            state <= ST_FULL;
            ibuf  <= 32'd0;
            exc   <= EXC_ADEL;
            valid <= 1'b1;
          end else if (imem_gnt) begin
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (imem_rvalid) begin
            if (drop) begin
              drop  <= 1'b0;
              state <= ST_FETCH;
            end else begin
              ibuf  <= imem_rdata;
              exc   <= EXC_NONE;
              valid <= 1'b1;
              state <= ST_FULL;
            end
          end
        end
        default: begin
          if (enable) begin
            pc    <= next_pc;
            state <= ST_FETCH;
            ibuf  <= 32'd0;
            exc   <= EXC_NONE;
            valid <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ifu.sv
// Directed bench for ifu: table of per-cycle stimulus/expectations
// plus hand-written AdEL, flush and async-reset sequences.
module tb_ifu;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] flush_pc = 32'd0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic [31:0] F_pc;
  logic [31:0] F_instr;
  logic        F_valid;
  logic [4:0]  F_exc;

  int checks = 0;
  int errors = 0;

  ifu dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .flush       (flush),
    .flush_pc    (flush_pc),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .F_pc        (F_pc),
    .F_instr     (F_instr),
    .F_valid     (F_valid),
    .F_exc       (F_exc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic        fl;
    logic [31:0] fpc;
    logic        rd;
    logic [31:0] rpc;
    logic        gnt;
    logic        rv;
    logic [31:0] rdata;
    logic        req;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        val;
    logic [4:0]  exc;
  } vec_t;

  vec_t tbl[29];

  function automatic vec_t v(
    input logic en, input logic fl, input logic [31:0] fpc,
    input logic rd, input logic [31:0] rpc,
    input logic gnt, input logic rv, input logic [31:0] rdata,
    input logic req, input logic [31:0] pc, input logic [31:0] instr,
    input logic val, input logic [4:0] exc);
    vec_t r;
    r.en = en; r.fl = fl; r.fpc = fpc; r.rd = rd; r.rpc = rpc;
    r.gnt = gnt; r.rv = rv; r.rdata = rdata;
    r.req = req; r.pc = pc; r.instr = instr; r.val = val; r.exc = exc;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, got, want);
    end
  endtask

  task automatic chk_out(input string nm, input logic req,
                         input logic [31:0] pc, input logic [31:0] instr,
                         input logic val, input logic [4:0] exc);
    chk({nm, ".req"},   {31'd0, imem_req}, {31'd0, req});
    chk({nm, ".addr"},  imem_addr, pc);
    chk({nm, ".pc"},    F_pc, pc);
    chk({nm, ".instr"}, F_instr, instr);
    chk({nm, ".valid"}, {31'd0, F_valid}, {31'd0, val});
    chk({nm, ".exc"},   {27'd0, F_exc}, {27'd0, exc});
  endtask

  // Called at posedge+1: drive, check current registered state, advance.
  task automatic step(input vec_t t, input string nm);
    enable      = t.en;
    flush       = t.fl;
    flush_pc    = t.fpc;
    redirect    = t.rd;
    redirect_pc = t.rpc;
    imem_gnt    = t.gnt;
    imem_rvalid = t.rv;
    imem_rdata  = t.rdata;
    #1;
    chk_out(nm, t.req, t.pc, t.instr, t.val, t.exc);
    @(posedge clk);
    #1;
  endtask

  initial begin
    //            en fl fpc          rd rpc          gn rv rdata         req pc           instr        val exc
    tbl[0]  = v(0, 0, 32'h0,      0, 32'h0,      1, 0, 32'h0,        1, 32'h3000, 32'h0,        0, 0);
    tbl[1]  = v(0, 0, 32'h0,      0, 32'h0,      0, 1, 32'h24080001, 0, 32'h3000, 32'h0,        0, 0);
    tbl[2]  = v(1, 0, 32'h0,      0, 32'h0,      0, 0, 32'h0,        0, 32'h3000, 32'h24080001, 1, 0);
    tbl[3]  = v(0, 0, 32'h0,      0, 32'h0,      1, 0, 32'h0,        1, 32'h3004, 32'h0,        0, 0);
    tbl[4]  = v(0, 0, 32'h0,      0, 32'h0,      0, 1, 32'h8c090000, 0, 32'h3004, 32'h0,        0, 0);
    tbl[5]  = v(1, 0, 32'h0,      0, 32'h0,      0, 0, 32'h0,        0, 32'h3004, 32'h8c090000, 1, 0);
    tbl[6]  = v(0, 0, 32'h0,      0, 32'h0,      1, 0, 32'h0,        1, 32'h3008, 32'h0,        0, 0);
    tbl[7]  = v(0, 0, 32'h0,      0, 32'h0,      0, 1, 32'h11000040, 0, 32'h3008, 32'h0,        0, 0);
    tbl[8]  = v(1, 0, 32'h0,      0, 32'h0,      0, 0, 32'h0,        0, 32'h3008, 32'h11000040, 1, 0);
    tbl[9]  = v(0, 0, 32'h0,      0, 32'h0,      1, 0, 32'h0,        1, 32'h300c, 32'h0,        0, 0);
    tbl[10] = v(0, 0, 32'h0,      1, 32'h3100,   0, 0, 32'h0,        0, 32'h300c, 32'h0,        0, 0);
    tbl[11] = v(0, 0, 32'h0,      0, 32'h0,      0, 1, 32'h21290001, 0, 32'h300c, 32'h0,        0, 0);
    tbl[12] = v(1, 0, 32'h0,      0, 32'h0,      0, 0, 32'h0,        0, 32'h300c, 32'h21290001, 1, 0);
    tbl[13] = v(0, 0, 32'h0,      0, 32'h0,      0, 0, 32'h0,        1, 32'h3100, 32'h0,        0, 0);
    tbl[14] = v(0, 0, 32'h0,      0, 32'h0,      1, 0, 32'h0,        1, 32'h3100, 32'h0,        0, 0);
    tbl[15] = v(0, 0, 32'h0,      0, 32'h0,      0, 1, 32'h3c011234, 0, 32'h3100, 32'h0,        0, 0);
    tbl[16] = v(0, 0, 32'h0,      0, 32'h0,      0, 0, 32'h0,        0, 32'h3100, 32'h3c011234, 1, 0);
    tbl[17] = v(0, 0, 32'h0,      1, 32'h3200,   0, 0, 32'h0,        0, 32'h3100, 32'h3c011234, 1, 0);
    tbl[18] = v(0, 0, 32'h0,      0, 32'h0,      0, 0, 32'h0,        0, 32'h3100, 32'h3c011234, 1, 0);
    tbl[19] = v(0, 0, 32'h0,      0, 32'h0,      0, 0, 32'h0,        0, 32'h3100, 32'h3c011234, 1, 0);
    tbl[20] = v(1, 0, 32'h0,      0, 32'h0,      0, 0, 32'h0,        0, 32'h3100, 32'h3c011234, 1, 0);
    tbl[21] = v(0, 0, 32'h0,      0, 32'h0,      1, 0, 32'h0,        1, 32'h3200, 32'h0,        0, 0);
    tbl[22] = v(0, 1, 32'h4180,   0, 32'h0,      0, 0, 32'h0,        0, 32'h3200, 32'h0,        0, 0);
    tbl[23] = v(0, 0, 32'h0,      0, 32'h0,      0, 0, 32'h0,        0, 32'h4180, 32'h0,        0, 0);
    tbl[24] = v(0, 0, 32'h0,      0, 32'h0,      0, 0, 32'h0,        0, 32'h4180, 32'h0,        0, 0);
    tbl[25] = v(0, 0, 32'h0,      0, 32'h0,      0, 1, 32'hdeadbeef, 0, 32'h4180, 32'h0,        0, 0);
    tbl[26] = v(0, 0, 32'h0,      0, 32'h0,      1, 0, 32'h0,        1, 32'h4180, 32'h0,        0, 0);
    tbl[27] = v(0, 0, 32'h0,      0, 32'h0,      0, 1, 32'h42000018, 0, 32'h4180, 32'h0,        0, 0);
    tbl[28] = v(1, 0, 32'h0,      0, 32'h0,      0, 0, 32'h0,        0, 32'h4180, 32'h42000018, 1, 0);

    // Reset state, with a stray grant that must not produce a request.
    imem_gnt = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_out("rst", 0, 32'h3000, 32'h0, 0, 0);
    imem_gnt = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;

    for (int i = 0; i < 29; i++)
      step(tbl[i], $sformatf("v%0d", i));

    // Redirect to a misaligned target, then past the top of memory.
    step(v(0,0,0, 0,0,          1,0,0,            1,32'h4184,0,0,0),            "b0");
    step(v(0,0,0, 1,32'h3002,   0,0,0,            0,32'h4184,0,0,0),            "b1");
    step(v(0,0,0, 0,0,          0,1,32'h24080002, 0,32'h4184,0,0,0),            "b2");
    step(v(1,0,0, 0,0,          0,0,0,            0,32'h4184,32'h24080002,1,0), "b3");
    step(v(0,0,0, 0,0,          1,0,0,            0,32'h3002,0,0,0),            "b4");
    step(v(0,0,0, 0,0,          0,0,0,            0,32'h3002,0,1,4),            "b5");
    step(v(1,0,0, 1,32'h7000,   0,0,0,            0,32'h3002,0,1,4),            "b6");
    step(v(0,0,0, 0,0,          0,0,0,            0,32'h7000,0,0,0),            "b7");
    step(v(0,0,0, 0,0,          0,0,0,            0,32'h7000,0,1,4),            "b8");
    // Flush out of FULL to the top legal word, then flush on a grant.
    step(v(0,1,32'h6ffc, 0,0,   0,0,0,            0,32'h7000,0,1,4),            "b9");
    step(v(0,1,32'h3ffc, 0,0,   1,0,0,            1,32'h6ffc,0,0,0),            "b10");
    step(v(0,0,0, 0,0,          0,1,32'hbadbad00, 0,32'h3ffc,0,0,0),            "b11");
    step(v(0,0,0, 0,0,          1,0,0,            1,32'h3ffc,0,0,0),            "b12");

    // Asynchronous reset while a request is outstanding.
    #3;
    reset = 1'b0;
    #1;
    chk_out("arst", 0, 32'h3000, 32'h0, 0, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Flush and redirect together: redirect must be ignored.
    step(v(0,0,0, 0,0,          1,0,0,            1,32'h3000,0,0,0),            "c0");
    step(v(0,1,32'h5000, 1,32'h3300, 0,1,32'h11111111, 0,32'h3000,0,0,0),      "c1");
    step(v(0,0,0, 0,0,          1,0,0,            1,32'h5000,0,0,0),            "c2");
    step(v(0,0,0, 0,0,          0,1,32'h0000000c, 0,32'h5000,0,0,0),            "c3");
    step(v(1,0,0, 0,0,          0,0,0,            0,32'h5000,32'h0000000c,1,0), "c4");
    step(v(0,0,0, 0,0,          0,0,0,            1,32'h5004,0,0,0),            "c5");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
